// File: rtl/a2_bridge_arbiter.sv
// Arbitrates client requests onto the multiplexed Apple II bridge port and sequences timed read/write cycles.
// Define A2BRIDGE_ARB_RR_EN for round-robin among requesters 1..NUM_REQ-1 (requester 0 stays highest).
module a2_bridge_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                 clk_logic_i,
  input  logic                 system_reset_n_i,
  input  logic                 enable_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_wr_i,
  input  logic [3*NUM_REQ-1:0] req_sel_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [7:0]           rsp_data_o,
  output logic                 busy_o,
  output logic                 idle_sample_valid_o,
  output logic [7:0]           idle_sample_o,
  output logic [2:0]           a2_bridge_sel_o,
  output logic                 a2_bridge_rd_n_o,
  output logic                 a2_bridge_wr_n_o,
  output logic [7:0]           a2_bridge_d_o,
  output logic                 a2_bridge_d_oe_o,
  input  logic [7:0]           a2_bridge_d_i
);

  // state     | meaning
  // IDLE      | bus parked on sel 0, control lines sampled, arbitration open
  // READ      | sel and rd_n held while the bus settles, then data captured
  // W_SETUP   | sel and write data driven, wr_n still high
  // W_STROBE  | wr_n low for STROBE_CYCLES
  // W_RELEASE | wr_n high, sel/data held for hold time, response pulse

  localparam int         IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);
  localparam logic [2:0] STROBE_LOAD = 3'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_W_SETUP,
    S_W_STROBE,
    S_W_RELEASE
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     cur_idx_q;
  logic [2:0]           tmr_q;
  logic [1:0]           park_q;
  logic [2:0]           sel_q;
  logic                 rd_n_q;
  logic                 wr_n_q;
  logic [7:0]           d_q;
  logic                 d_oe_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [7:0]           rsp_data_q;
  logic [7:0]           idle_sample_q;
  logic                 idle_sample_valid_q;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_wr;
  logic [2:0]           win_sel;
  logic [7:0]           win_data;
  logic                 grant_ok;
  logic [1:0]           park_d;
  logic [NUM_REQ-1:0]   cur_onehot;

`ifdef A2BRIDGE_ARB_RR_EN
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (req_valid_i[0]) begin
      win_found = 1'b1;
    end
    // two passes give a rotating search that starts at the pointer
    for (int j = 1; j < NUM_REQ; j++) begin
      if (!win_found && req_valid_i[j] && (IDX_W'(j) >= ptr_q)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
    for (int j = 1; j < NUM_REQ; j++) begin
      if (!win_found && req_valid_i[j] && (IDX_W'(j) < ptr_q)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  assign ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : win_idx + IDX_W'(1);
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_valid_i[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end
`endif

  always_comb begin
    win_wr   = 1'b0;
    win_sel  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_wr   = req_wr_i[i];
        win_sel  = req_sel_i[3*i +: 3];
        win_data = req_data_i[8*i +: 8];
      end
    end
  end

  assign grant_ok = (state_q == S_IDLE) && enable_i && win_found;
  assign busy_o   = (state_q != S_IDLE);

  always_comb begin
    req_ready_o = '0;
    cur_onehot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = grant_ok && (win_idx == IDX_W'(i));
      cur_onehot[i]  = (cur_idx_q == IDX_W'(i));
    end
  end

  // count includes the current cycle, so a sample is taken once the bus has sat parked for a full cycle
  assign park_d = (sel_q == 3'd0 && !rd_n_q) ? ((park_q == 2'd2) ? 2'd2 : park_q + 2'd1) : 2'd0;

  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      state_q             <= S_IDLE;
      cur_idx_q           <= '0;
      tmr_q               <= '0;
      park_q              <= '0;
      sel_q               <= '0;
      rd_n_q              <= 1'b1;
      wr_n_q              <= 1'b1;
      d_q                 <= '0;
      d_oe_q              <= 1'b0;
      rsp_valid_q         <= '0;
      rsp_data_q          <= '0;
      idle_sample_q       <= 8'hFF;
      idle_sample_valid_q <= 1'b0;
`ifdef A2BRIDGE_ARB_RR_EN
      ptr_q               <= IDX_W'(1);
`endif
    end else begin
      rsp_valid_q         <= '0;
      idle_sample_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_ok) begin
            cur_idx_q <= win_idx;
            sel_q     <= win_sel;
            park_q    <= '0;
`ifdef A2BRIDGE_ARB_RR_EN
            if (win_idx != '0) ptr_q <= ptr_d;
`endif
            if (win_wr) begin
              state_q <= S_W_SETUP;
              d_q     <= win_data;
              d_oe_q  <= 1'b1;
              rd_n_q  <= 1'b1;
              wr_n_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              rd_n_q  <= 1'b0;
              d_oe_q  <= 1'b0;
              tmr_q   <= SETTLE_LOAD;
            end
          end else begin
            sel_q  <= '0;
            wr_n_q <= 1'b1;
            d_oe_q <= 1'b0;
            rd_n_q <= !enable_i;
            park_q <= park_d;
            if (park_d != 2'd0) begin
              idle_sample_q       <= a2_bridge_d_i;
              idle_sample_valid_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (tmr_q == 3'd0) begin
            rsp_data_q  <= a2_bridge_d_i;
            rsp_valid_q <= cur_onehot;
            sel_q       <= '0;
            park_q      <= '0;
            state_q     <= S_IDLE;
          end else begin
            tmr_q <= tmr_q - 3'd1;
          end
        end
        S_W_SETUP: begin
          wr_n_q  <= 1'b0;
          tmr_q   <= STROBE_LOAD;
          state_q <= S_W_STROBE;
        end
        S_W_STROBE: begin
          if (tmr_q == 3'd0) begin
            wr_n_q      <= 1'b1;
            rsp_valid_q <= cur_onehot;
            state_q     <= S_W_RELEASE;
          end else begin
            tmr_q <= tmr_q - 3'd1;
          end
        end
        S_W_RELEASE: begin
          // rd_n stays high here so it cannot fall on the same edge d_oe is released
          sel_q   <= '0;
          d_oe_q  <= 1'b0;
          rd_n_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_data_o          = rsp_data_q;
  assign idle_sample_valid_o = idle_sample_valid_q;
  assign idle_sample_o       = idle_sample_q;
  assign a2_bridge_sel_o     = sel_q;
  assign a2_bridge_rd_n_o    = rd_n_q;
  assign a2_bridge_wr_n_o    = wr_n_q;
  assign a2_bridge_d_o       = d_q;
  assign a2_bridge_d_oe_o    = d_oe_q;

endmodule

// File: tb/tb_a2_bridge_arbiter.sv
// Bench for a2_bridge_arbiter: directed steps then random traffic against a transaction-level model.
module tb_a2_bridge_arbiter;
  localparam int N      = 4;
  localparam int SETTLE = 1;
  localparam int STROBE = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_wr = '0;
  logic [3*N-1:0] req_sel = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_data;
  logic           busy;
  logic           samp_v;
  logic [7:0]     samp;
  logic [2:0]     sel;
  logic           rd_n;
  logic           wr_n;
  logic [7:0]     d_o;
  logic           d_oe;
  logic [7:0]     d_in = 8'h00;

  always #5 clk = ~clk;

  a2_bridge_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(SETTLE), .STROBE_CYCLES(STROBE)) dut (
    .clk_logic_i(clk), .system_reset_n_i(rst_n), .enable_i(enable),
    .req_valid_i(req_valid), .req_wr_i(req_wr), .req_sel_i(req_sel), .req_data_i(req_data),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy),
    .idle_sample_valid_o(samp_v), .idle_sample_o(samp),
    .a2_bridge_sel_o(sel), .a2_bridge_rd_n_o(rd_n), .a2_bridge_wr_n_o(wr_n),
    .a2_bridge_d_o(d_o), .a2_bridge_d_oe_o(d_oe), .a2_bridge_d_i(d_in)
  );

  int checks = 0;
  int errors = 0;

  // requester side: each pending request is held until granted
  bit         pend[N];
  bit         pwr[N];
  logic [2:0] psel[N];
  logic [7:0] pdata[N];
  int         grant_log[$];
  int         issued, completed;

  // transaction-level model of the bridge
  bit         m_busy;
  int         m_age;
  int         m_idx;
  bit         m_wr;
  logic [2:0] m_sel;
  logic [7:0] m_data;
  logic       m_rdn;
  logic [7:0] m_rsp_data;
  logic [N-1:0] m_rsp_valid;
  logic [7:0] m_samp;
  logic       m_sv;
  int         m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_idx = 0; m_wr = 0; m_sel = '0; m_data = '0;
    m_rdn = 1'b1; m_rsp_data = 8'h00; m_rsp_valid = '0; m_samp = 8'hFF; m_sv = 1'b0; m_ptr = 1;
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1;
    return 0;
  endfunction

  function automatic int pick();
    if (!enable) return -1;
    if (pend[0]) return 0;
`ifdef A2BRIDGE_ARB_RR_EN
    for (int k = 0; k < N - 1; k++) begin
      int j = 1 + ((m_ptr - 1 + k) % (N - 1));
      if (pend[j]) return j;
    end
`else
    for (int j = 1; j < N; j++) if (pend[j]) return j;
`endif
    return -1;
  endfunction

  task automatic new_req(input int i, input bit wr, input logic [2:0] s, input logic [7:0] d);
    pend[i] = 1; pwr[i] = wr; psel[i] = s; pdata[i] = d; issued++;
  endtask

  // one clock: drive requests, check grant, advance model at the edge, check registered outputs
  task automatic cycle();
    int w;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_wr[i] = pwr[i];
      req_sel[3*i +: 3] = psel[i];
      req_data[8*i +: 8] = pdata[i];
    end
    #2;
    w = m_busy ? -1 : pick();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_busy);
    @(posedge clk);
    m_rsp_valid = '0;
    if (m_busy) begin
      m_sv = 1'b0;
      if (!m_wr && m_age == SETTLE) begin
        m_busy = 0; m_rsp_valid[m_idx] = 1'b1; m_rsp_data = d_in; m_rdn = 1'b0; completed++;
      end else if (m_wr && m_age == STROBE + 2) begin
        m_busy = 0; m_rdn = 1'b1;
      end else begin
        m_age++;
        if (m_wr && m_age == STROBE + 2) begin
          m_rsp_valid[m_idx] = 1'b1; completed++;
        end
      end
    end else if (w >= 0) begin
      m_busy = 1; m_age = 1; m_idx = w; m_wr = pwr[w]; m_sel = psel[w]; m_data = pdata[w];
      pend[w] = 0; m_sv = 1'b0; grant_log.push_back(w);
`ifdef A2BRIDGE_ARB_RR_EN
      if (w != 0) m_ptr = (w == N - 1) ? 1 : w + 1;
`endif
    end else begin
      if (!m_rdn) begin
        m_samp = d_in; m_sv = 1'b1;
      end else begin
        m_sv = 1'b0;
      end
      m_rdn = !enable;
    end
    #1;
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_data", rsp_data, m_rsp_data);
    chk("samp_valid", samp_v, m_sv);
    chk("samp", samp, m_samp);
    if (m_busy) begin
      chk("sel", sel, m_sel);
      if (m_wr) begin
        chk("w_d_o", d_o, m_data);
        chk("w_d_oe", d_oe, 1);
        chk("w_rd_n", rd_n, 1);
        chk("w_wr_n", wr_n, (m_age >= 2 && m_age <= STROBE + 1) ? 32'd0 : 32'd1);
      end else begin
        chk("r_d_oe", d_oe, 0);
        chk("r_rd_n", rd_n, 0);
        chk("r_wr_n", wr_n, 1);
      end
    end else begin
      chk("idle_sel", sel, 0);
      chk("idle_wr_n", wr_n, 1);
      chk("idle_d_oe", d_oe, 0);
      chk("idle_rd_n", rd_n, m_rdn);
    end
    chk("strobes_exclusive", rd_n | wr_n, 1);
    chk("oe_vs_rd", !(d_oe && !rd_n), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_busy || any_pend()) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", m_busy || any_pend(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    issued = 0; completed = 0;
    model_reset();
    enable = 1'b1;
    d_in = 8'hA5;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_sel", sel, 0);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_d_o", d_o, 0);
    chk("rst_d_oe", d_oe, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_samp", samp, 8'hFF);
    chk("rst_samp_valid", samp_v, 0);
    chk("rst_busy", busy, 0);
    #1 rst_n = 1'b1;

    // park and sample
    cycle();
    chk("park_rd_n", rd_n, 0);
    chk("park_sel", sel, 0);
    cycle();
    chk("park_samp", samp, 8'hA5);
    chk("park_samp_valid", samp_v, 1);
    cycle();

    // read from requester 1
    new_req(1, 0, 3'd2, 8'h00);
    d_in = 8'h34;
    cycle();
    chk("rd_sel", sel, 3'd2);
    chk("rd_rd_n", rd_n, 0);
    cycle();
    chk("rd_rsp_valid", rsp_valid, 4'b0010);
    chk("rd_rsp_data", rsp_data, 8'h34);
    cycle();

    // write from requester 2
    new_req(2, 1, 3'd1, 8'h5A);
    cycle();
    chk("wr_setup_oe", d_oe, 1);
    chk("wr_setup_d", d_o, 8'h5A);
    chk("wr_setup_wr_n", wr_n, 1);
    cycle();
    chk("wr_strobe1", wr_n, 0);
    cycle();
    chk("wr_strobe2", wr_n, 0);
    chk("wr_strobe_sel", sel, 3'd1);
    cycle();
    chk("wr_rsp_valid", rsp_valid, 4'b0100);
    chk("wr_release_wr_n", wr_n, 1);
    chk("wr_release_oe", d_oe, 1);
    cycle();
    chk("wr_done_oe", d_oe, 0);
    chk("wr_done_sel", sel, 0);

    // simultaneous requests
    grant_log.delete();
    new_req(0, 0, 3'd4, 8'h00);
    new_req(1, 0, 3'd5, 8'h00);
    new_req(3, 0, 3'd6, 8'h00);
    drain(40);
    chk("order_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
`ifdef A2BRIDGE_ARB_RR_EN
      chk("order_0", grant_log[0], 0);
      chk("order_1", grant_log[1], 3);
      chk("order_2", grant_log[2], 1);
`else
      chk("order_0", grant_log[0], 0);
      chk("order_1", grant_log[1], 1);
      chk("order_2", grant_log[2], 3);
`endif
    end

    // requesters 1 and 3 re-requesting continuously
    grant_log.delete();
    for (int c = 0; c < 40 && grant_log.size() < 4; c++) begin
      if (!pend[1]) new_req(1, 0, 3'd7, 8'h00);
      if (!pend[3]) new_req(3, 0, 3'd3, 8'h00);
      d_in = 8'($urandom_range(255));
      cycle();
    end
    chk("contend_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
`ifdef A2BRIDGE_ARB_RR_EN
        chk("rr_alternate", grant_log[k] != grant_log[k-1], 1);
`else
        chk("fixed_prio", grant_log[k], 1);
`endif
      end
    end
    drain(40);

    // reset while wr_n is low
    new_req(2, 1, 3'd5, 8'hC3);
    cycle();
    cycle();
    chk("pre_rst_strobe", wr_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_n", wr_n, 1);
    chk("mid_rst_d_oe", d_oe, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    cycle();
    chk("post_rst_rsp", rsp_valid, 0);

    // enable gating
    enable = 1'b0;
    new_req(1, 0, 3'd3, 8'h00);
    cycle();
    cycle();
    chk("en_off_rd_n", rd_n, 1);
    chk("en_off_ready", req_ready, 0);
    enable = 1'b1;
    cycle();
    chk("en_on_sel", sel, 3'd3);
    drain(20);

    // withdrawn request leaves the bus alone
    enable = 1'b0;
    new_req(3, 1, 3'd6, 8'h11);
    cycle();
    pend[3] = 0;
    enable = 1'b1;
    cycle();
    cycle();
    chk("withdraw_busy", busy, 0);

    // random traffic
    issued = 0;
    completed = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(3) == 0)
          new_req(i, 1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom_range(255)));
      end
      enable = ($urandom_range(9) != 0);
      d_in = 8'($urandom_range(255));
      cycle();
    end
    enable = 1'b1;
    drain(200);
    chk("no_lost", completed, issued);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/a2_bridge_arbiter.md
Name: a2_bridge_arbiter

Overview:
- Owns the multiplexed Apple II bus bridge port: 3-bit select, rd_n/wr_n strobes, and 8-bit bidirectional data.
- Arbitrates transaction requests from multiple clients: address/data sampler, bus data driver, GPIO/control writer, SoC register access.
- Sequences each request as a timed read or write cycle on the bridge and returns read data to the client.
- In IDLE, parks the bridge on select 0 with rd_n low and continuously samples the control lines.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); index 0 is highest priority.
- SETTLE_CYCLES, 1, cycles select/rd_n are held before read data is captured (1..7).
- STROBE_CYCLES, 1, cycles wr_n is held low on a write (1..7).

Ports:
- clk_logic_i  in  1  logic clock
- system_reset_n_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  bridge use permitted; low blocks new grants
- req_valid_i  in  NUM_REQ  per-requester request
- req_wr_i  in  NUM_REQ  1=write, 0=read
- req_sel_i  in  3*NUM_REQ  bridge select per requester; slice i = [3i+2:3i]
- req_data_i  in  8*NUM_REQ  write data per requester
- req_ready_o  out  NUM_REQ  one-hot grant/accept
- rsp_valid_o  out  NUM_REQ  one-hot completion pulse
- rsp_data_o  out  8  captured read data; valid while rsp_valid_o is nonzero
- busy_o  out  1  state != IDLE
- idle_sample_valid_o  out  1  idle_sample_o updated this cycle
- idle_sample_o  out  8  last control-line sample
- a2_bridge_sel_o  out  3  bridge select
- a2_bridge_rd_n_o  out  1  read strobe
- a2_bridge_wr_n_o  out  1  write strobe
- a2_bridge_d_o  out  8  bridge write data
- a2_bridge_d_oe_o  out  1  bridge data output enable
- a2_bridge_d_i  in  8  bridge read data

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - sel=0, rd_n=1, wr_n=1, d_o=0, d_oe=0.
  - req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, idle_sample_o=8'hFF, idle_sample_valid_o=0, busy_o=0.
  - State IDLE, park counter 0, priority pointer at 1.
- All outputs are registered except req_ready_o and busy_o, which are combinational from state.
- States: IDLE, READ, W_SETUP, W_STROBE, W_RELEASE.
- IDLE:
  - Drives sel=0, wr_n=1, d_oe=0; rd_n = !enable_i.
  - Park counter counts cycles with sel=0 and rd_n=0, saturating at 2.
  - When the counter is ≥1, each cycle: idle_sample_o <= a2_bridge_d_i and idle_sample_valid_o=1. Otherwise idle_sample_valid_o=0.
- Arbitration:
  - Only in IDLE and only with enable_i=1; winner = lowest index with valid set.
  - req_ready_o[winner]=1 in the same cycle; the transfer occurs when valid&ready.
  - Requesters must hold valid and payload until ready. Dropping valid early withdraws the request with no bus activity.
  - Payload is latched on the accept edge.
  - Accepted read → READ; accepted write → W_SETUP.
- READ (accept at cycle T):
  - T+1..T+SETTLE_CYCLES: sel=req_sel, rd_n=0, d_oe=0.
  - At the end of cycle T+SETTLE_CYCLES, capture d_i into rsp_data_o.
  - Cycle T+SETTLE_CYCLES+1: rsp_valid_o[i]=1 for one cycle; state IDLE (new accept allowed this cycle); sel returns to 0, rd_n stays 0.
  - Park counter restarts at 0 after a read.
- Write (accept at cycle T):
  - W_SETUP, cycle T+1: sel=req_sel, d_o=data, d_oe=1, rd_n=1, wr_n=1.
  - W_STROBE, STROBE_CYCLES cycles: wr_n=0.
  - W_RELEASE, 1 cycle: wr_n=1; sel, d_o and d_oe held (hold time); rsp_valid_o[i]=1.
  - Next cycle: IDLE with d_oe=0, sel=0.
- Guarantees:
  - wr_n is never low while sel changes.
  - rd_n and wr_n are never both low.
  - d_oe is never high while rd_n is low.
- enable_i falling mid-transaction: the current transaction completes; no new grants follow.
- Simultaneous valids: exactly one grant; others wait; no request is lost.

Optional Feature:
- Macro A2BRIDGE_ARB_RR_EN.
- Defined:
  - Requester 0 keeps absolute priority.
  - Requesters 1..NUM_REQ-1 are round-robin; the pointer advances to the index after the last granted non-zero requester and wraps to 1 after NUM_REQ-1.
- Undefined: pure fixed priority; pointer logic absent.

Test Plan:
- Reset then idle, enable_i=1, d_i=8'hA5 → sel=0, rd_n=0 from cycle 1; idle_sample_o=8'hA5 with valid from cycle 2.
- Read req1 sel=3'd2, d_i=8'h34, SETTLE_CYCLES=1 → ready at T; sel=2, rd_n=0 at T+1; rsp_valid_o=4'b0010, rsp_data_o=8'h34 at T+2.
- Write req2 sel=3'd1 data=8'h5A, STROBE_CYCLES=2 → d_oe=1 at T+1, wr_n=0 at T+2..T+3, rsp_valid at T+4, d_oe=0 at T+5; sel stable while wr_n low.
- req0, req1, req3 valid together → order 0, 1, 3. With RR_EN and req1/req3 re-requesting continuously → alternates 1, 3, 1, 3.
- Assert reset during W_STROBE → wr_n=1, d_oe=0 within the same cycle; no rsp_valid.
- enable_i=0 with req pending → no ready, rd_n=1; raise enable_i → grant next cycle.
